// File: rtl/nr4sd_pp_accumulator_pkg.sv
// Shared constants and state encoding for the NR4SD partial-product
// accumulator; reused by the multiplier top and its tests.
package nr4sd_pp_accumulator_pkg;

  localparam int N_PP_DEF  = 8;
  localparam int PP_W_DEF  = 17;
  localparam int OUT_W_DEF = 32;
  localparam int SHIFT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/nr4sd_pp_accumulator_shifter.sv
// Zero-extends one partial-product row and applies its radix-4 weight.
// Purely combinational.
module nr4sd_pp_shifter
  import nr4sd_pp_accumulator_pkg::*;
#(
  parameter int N_PP  = N_PP_DEF,
  parameter int PP_W  = PP_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int IDX_W = $clog2(N_PP)
) (
  input  logic [PP_W-1:0]  pp,
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] row
);

  assign row = OUT_W'(pp) << (SHIFT * int'(idx));

endmodule

// File: rtl/nr4sd_pp_accumulator.sv
// Sequential reduction of 8 NR4SD/MB partial products plus the COR word
// into a 32-bit product, one weighted row per cycle.
module nr4sd_pp_accumulator
  import nr4sd_pp_accumulator_pkg::*;
#(
  parameter int N_PP  = N_PP_DEF,
  parameter int PP_W  = PP_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_PP*PP_W-1:0] pp_flat,
  input  logic [OUT_W-1:0]     cor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     product,
  output logic                 busy
);

  localparam int IDX_W = $clog2(N_PP);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PP - 1);

  acc_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] row;
  logic [OUT_W-1:0] acc_nxt;
  logic [PP_W-1:0]  rows [N_PP];
  logic             accept;

  assign accept = (state == IDLE) && in_valid && in_ready;

  nr4sd_pp_shifter #(
    .N_PP  (N_PP),
    .PP_W  (PP_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .IDX_W (IDX_W)
  ) u_shift (
    .pp  (rows[idx]),
    .idx (idx),
    .row (row)
  );

  // Wrap-around is intended: COR relies on modular arithmetic.
  assign acc_nxt = acc + row;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_PP; i++) begin
        rows[i] <= pp_flat[i*PP_W +: PP_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc      <= cor;
            idx      <= '0;
            state    <= ACC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ACC: begin
          acc <= acc_nxt;
          if (idx == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            product   <= acc_nxt;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nr4sd_pp_accumulator.sv
// Scoreboard bench for nr4sd_pp_accumulator with directed vectors.
module tb_nr4sd_pp_accumulator;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [135:0] pp_flat;
  logic [31:0]  cor;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  product;
  logic         busy;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [16:0] rv[8];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_pop = -100;
  logic        ov_q = 1'b0;

  nr4sd_pp_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp_flat   (pp_flat),
    .cor       (cor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency on rise of out_valid, product on handshake.
  always @(negedge clk) begin
    if (rst) begin
      ov_q = 1'b0;
    end else begin
      if (out_valid && !ov_q) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL latency: out_valid with empty scoreboard");
        end else begin
          chk("latency", cyc - sb[0].cyc, 32'd8);
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL product: unexpected %h", product);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("product", product, e.prod);
          last_pop = cyc + 1;
        end
      end
      ov_q = out_valid;
    end
  end

  task automatic clr_rows();
    for (int i = 0; i < 8; i++) rv[i] = '0;
  endtask

  task automatic send(input logic [31:0] c, input logic [31:0] e,
                      output int ac);
    bit got;
    for (int i = 0; i < 8; i++) pp_flat[i*17 +: 17] = rv[i];
    cor = c;
    in_valid = 1'b1;
    got = 0;
    ac = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept: in_ready 0 expected 1 within 100 cycles");
    end else begin
      ac = cyc + 1;
      sb.push_back('{e, ac});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ac;
    int a;
    int b;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    pp_flat = '0;
    cor = '0;
    clr_rows();
    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready, 32'd1);
    chk("rst out_valid", out_valid, 32'd0);
    chk("rst busy", busy, 32'd0);
    chk("rst product", product, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // COR passes straight through when all rows are zero
    clr_rows();
    send(32'h12345678, 32'h12345678, ac);
    chk("acc busy", busy, 32'd1);
    chk("acc in_ready", in_ready, 32'd0);
    in_valid = 1'b0;
    drain();

    clr_rows();
    rv[0] = 17'h00001;
    send(32'h0, 32'h00000001, ac);
    in_valid = 1'b0;
    drain();

    clr_rows();
    rv[7] = 17'h1FFFF;
    send(32'h0, 32'h7FFFC000, ac);
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 8; i++) rv[i] = 17'h1FFFF;
    send(32'h0, 32'hAAA9AAAB, ac);
    in_valid = 1'b0;
    drain();

    send(32'h60000000, 32'h0AA9AAAB, ac);
    in_valid = 1'b0;
    drain();

    // Backpressure in DONE
    out_ready = 1'b0;
    clr_rows();
    rv[0] = 17'h5;
    send(32'h0, 32'h5, ac);
    in_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp out_valid", out_valid, 32'd1);
      chk("bp product", product, 32'h5);
      chk("bp in_ready", in_ready, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    clr_rows();
    rv[1] = 17'h1;
    send(32'h0, 32'h4, ac);
    chk("bp next accept", ac, last_pop + 1);
    in_valid = 1'b0;
    drain();

    // Async reset at idx=3 discards the in-flight set
    for (int i = 0; i < 8; i++) rv[i] = 17'h1ABCD;
    send(32'hDEADBEEF, 32'h0, ac);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst in_ready", in_ready, 32'd1);
    chk("arst out_valid", out_valid, 32'd0);
    chk("arst busy", busy, 32'd0);
    chk("arst product", product, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clr_rows();
    rv[0] = 17'h1;
    send(32'h0, 32'h1, ac);
    in_valid = 1'b0;
    drain();

    // End-to-end: radix-4 digit rows of b times a
    a = 2846;
    b = 15953;
    for (int i = 0; i < 8; i++) rv[i] = 17'(a * ((b >> (2 * i)) & 3));
    send(32'h0, 32'd45402238, ac);
    chk("e2e model", a * b, 32'd45402238);

    // Back-to-back with in_valid held high
    for (int i = 0; i < 8; i++) rv[i] = 17'h1FFFF;
    send(32'h60000000, 32'h0AA9AAAB, ac);
    clr_rows();
    rv[7] = 17'h1FFFF;
    send(32'h0, 32'h7FFFC000, ac);
    clr_rows();
    rv[2] = 17'h3;
    send(32'h10, 32'h40, ac);
    in_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nr4sd_pp_accumulator.md
Name: nr4sd_pp_accumulator

Overview:
Sequential partial-product reduction stage. It sits directly downstream of the NR4SD-/MB partial-product generators and the COR correction block in the 16-bit modified-Booth multiplier. It accepts one set of 8 partial products plus the COR word through a valid/ready handshake. It then adds one weighted PP per cycle into a 32-bit accumulator and presents the final product with a valid/ready handshake.

Parameters:
N_PP, 8, number of partial products (7 NR4SD- rows + 1 MB row)
PP_W, 17, width of each partial product
OUT_W, 32, width of accumulator, COR and product
SHIFT, 2, weight step per row; row i is shifted left by SHIFT*i

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  PP set and COR are valid
in_ready  output  1  block can accept a new set
pp_flat  input  N_PP*PP_W  row i occupies bits [i*PP_W +: PP_W]
cor  input  OUT_W  correction constant from the COR block
out_valid  output  1  product is valid
out_ready  input  1  consumer accepts the product
product  output  OUT_W  final product
busy  output  1  high in ACC or DONE

Behaviour:
- One clock (clk); reset asynchronous and active-high (rst). On rst:
  - state=IDLE, idx=0, acc=0
  - in_ready=1, out_valid=0, busy=0, product=0
- State IDLE:
  - in_ready=1.
  - Accept on a rising edge with in_valid&&in_ready: latch all N_PP rows into a register array, set acc<=cor, idx<=0, go to ACC.
  - Inputs are not needed after the accept edge.
- State ACC:
  - in_ready=0, busy=1.
  - Each edge: acc <= acc + (zero-extend(pp[idx]) << SHIFT*idx), truncated mod 2^OUT_W, then idx<=idx+1.
  - On the edge that adds row N_PP-1, go to DONE.
- State DONE:
  - out_valid=1, product=acc, held stable until out_valid&&out_ready on an edge.
  - On that edge go to IDLE; out_valid drops the same edge.
  - The next set is accepted at the earliest one edge later (no accept in DONE).
- Latency:
  - Accept at edge t; out_valid rises after edge t+N_PP (8 ACC cycles).
  - Minimum throughput: one product per N_PP+2 cycles.
- Arithmetic:
  - Rows are unsigned; sign is carried entirely by COR.
  - Overflow past bit OUT_W-1 is discarded silently; this is intended, because the COR constant relies on wrap-around.
- Boundary conditions:
  - in_valid during ACC/DONE is ignored; the upstream must hold it.
  - out_ready high before DONE has no effect.
  - out_ready tied high: DONE lasts exactly one cycle.
  - rst mid-ACC or mid-DONE: immediate return to reset values; the in-flight product is discarded and no out_valid pulse occurs.
  - idx never exceeds N_PP-1; it wraps to 0 on entering IDLE.
- product is registered; no combinational path from inputs to outputs except none (both in_ready and out_valid are decoded from state only).

Decomposition:
- Shared package/header: state encoding (IDLE=2'd0, ACC=2'd1, DONE=2'd2), default N_PP/PP_W/OUT_W/SHIFT constants. The multiplier top and tests reuse them.
- One natural sub-module: nr4sd_pp_shifter. It is combinational; it takes pp[idx] and idx and outputs the OUT_W-bit zero-extended, shifted row. The top holds the FSM, row register array and accumulator.

Test Plan:
- All rows 0, cor=32'h12345678 -> out_valid exactly 8 cycles after accept, product=32'h12345678.
- Row0=17'h00001, others 0, cor=0 -> product=32'h00000001; row7=17'h1FFFF only, cor=0 -> product=32'h7FFFC000.
- All rows 17'h1FFFF, cor=0 -> 32'hAAA9AAAB; same rows with cor=32'h60000000 -> 32'h0AA9AAAB (wrap, no error).
- Backpressure: out_ready low for 5 cycles in DONE -> product and out_valid stable, in_ready=0 throughout. Then pulse out_ready -> IDLE, and the next set is accepted one edge later.
- rst asserted asynchronously at ACC idx=3 -> outputs return to reset values without waiting for clk. After release, a fresh set (row0=1, cor=0) yields product=1 with no stale contribution.
- End-to-end with the encoder chain, a=16'd2846, b=16'd15953 -> product=32'd45402238. Back-to-back sets with in_valid held high -> each accepted only in IDLE; the products arrive in order.
